// File: rtl/psc_axil_regs.sv
// AXI4-Lite register block for the power-supply controller (DAC setpoint, ramp table, DCCT cal, status).
// Define PSC_RAMP_AUTOINC_EN to post-increment RAMPADDR on every accepted RAMPDATA write.
module psc_axil_regs #(
  parameter logic [31:0] FPGA_VERSION = 32'd1,
  parameter int unsigned ADDR_W       = 12
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [ADDR_W-1:0] s_axi_awaddr,
  input  logic              s_axi_awvalid,
  output logic              s_axi_awready,
  input  logic [31:0]       s_axi_wdata,
  input  logic [3:0]        s_axi_wstrb,
  input  logic              s_axi_wvalid,
  output logic              s_axi_wready,
  output logic [1:0]        s_axi_bresp,
  output logic              s_axi_bvalid,
  input  logic              s_axi_bready,
  input  logic [ADDR_W-1:0] s_axi_araddr,
  input  logic              s_axi_arvalid,
  output logic              s_axi_arready,
  output logic [31:0]       s_axi_rdata,
  output logic [1:0]        s_axi_rresp,
  output logic              s_axi_rvalid,
  input  logic              s_axi_rready,
  output logic [7:0]        fp_leds,
  output logic [19:0]       dac_setpt,
  output logic [1:0]        dac_opmode,
  output logic [15:0]       ramp_len,
  output logic              ramp_we,
  output logic [15:0]       ramp_addr,
  output logic [19:0]       ramp_wdata,
  output logic              ramp_run,
  output logic [15:0]       dcct0_offset,
  output logic [15:0]       dcct0_gain,
  output logic [15:0]       dcct1_offset,
  output logic [15:0]       dcct1_gain,
  input  logic [31:0]       status
);
  localparam logic [1:0] RESP_OKAY = 2'b00, RESP_SLVERR = 2'b10;
  localparam logic [ADDR_W-1:0] A_VERSION  = ADDR_W'(32'h000), A_FP       = ADDR_W'(32'h004),
                                A_SETPT    = ADDR_W'(32'h108), A_OPMODE   = ADDR_W'(32'h10C),
                                A_RAMPLEN  = ADDR_W'(32'h118), A_RAMPADDR = ADDR_W'(32'h11C),
                                A_RAMPDATA = ADDR_W'(32'h120), A_RAMPRUN  = ADDR_W'(32'h124),
                                A_D0OFF    = ADDR_W'(32'h150), A_D0GAIN   = ADDR_W'(32'h154),
                                A_D1OFF    = ADDR_W'(32'h158), A_D1GAIN   = ADDR_W'(32'h15C),
                                A_STATUS   = ADDR_W'(32'h200);

  typedef enum logic [1:0] {W_IDLE, W_HAVE_AW, W_HAVE_W, W_RESP} wstate_e;
  typedef enum logic {R_IDLE, R_VALID} rstate_e;

  wstate_e wstate_q, wstate_d;
  rstate_e rstate_q, rstate_d;
  logic              commit;
  logic [ADDR_W-1:0] awaddr_q, waddr, wa;
  logic [31:0]       wdata_q, wd, merged;
  logic [3:0]        wstrb_q, ws;
  logic [32:0]       wsel, rsel;
  logic              wok;
  logic [1:0]        bresp_q, rresp_q;
  logic [31:0]       rdata_q;
  logic [7:0]        fp_leds_q;
  logic [19:0]       dac_setpt_q, ramp_wdata_q;
  logic [1:0]        dac_opmode_q;
  logic [15:0]       ramp_len_q, rampaddr_reg_q, ramp_addr_q;
  logic [15:0]       d0off_q, d0gain_q, d1off_q, d1gain_q;
  logic              ramp_we_q, ramp_run_q;

  // Returns {mapped, read value}; also supplies the old value for byte-masked writes.
  function automatic logic [32:0] reg_rd(input logic [ADDR_W-1:0] a);
    logic [32:0] r;
    r = '0;
    case ({a[ADDR_W-1:2], 2'b00})
      A_VERSION:             r = {1'b1, FPGA_VERSION};
      A_FP:                  r = {1'b1, 24'd0, fp_leds_q};
      A_SETPT:               r = {1'b1, {12{dac_setpt_q[19]}}, dac_setpt_q};
      A_OPMODE:              r = {1'b1, 30'd0, dac_opmode_q};
      A_RAMPLEN:             r = {1'b1, 16'd0, ramp_len_q};
      A_RAMPADDR:            r = {1'b1, 16'd0, rampaddr_reg_q};
      A_RAMPDATA, A_RAMPRUN: r = {1'b1, 32'd0};
      A_D0OFF:               r = {1'b1, 16'd0, d0off_q};
      A_D0GAIN:              r = {1'b1, 16'd0, d0gain_q};
      A_D1OFF:               r = {1'b1, 16'd0, d1off_q};
      A_D1GAIN:              r = {1'b1, 16'd0, d1gain_q};
      A_STATUS:              r = {1'b1, status};
      default:               r = '0;
    endcase
    return r;
  endfunction

  function automatic logic [31:0] wmerge(input logic [31:0] old, input logic [31:0] d,
                                         input logic [3:0] s);
    logic [31:0] m;
    for (int i = 0; i < 4; i++) m[8*i +: 8] = s[i] ? d[8*i +: 8] : old[8*i +: 8];
    return m;
  endfunction

  // Address/data come from the live bus or the earlier-captured half, whichever arrived first.
  always_comb begin
    waddr  = (wstate_q == W_HAVE_AW) ? awaddr_q : s_axi_awaddr;
    wd     = (wstate_q == W_HAVE_W)  ? wdata_q  : s_axi_wdata;
    ws     = (wstate_q == W_HAVE_W)  ? wstrb_q  : s_axi_wstrb;
    wa     = {waddr[ADDR_W-1:2], 2'b00};
    wsel   = reg_rd(waddr);
    wok    = wsel[32] && (wa != A_VERSION) && (wa != A_STATUS);
    merged = wmerge(wsel[31:0], wd, ws);
    rsel   = reg_rd(s_axi_araddr);
  end

  always_comb begin
    wstate_d      = wstate_q;
    s_axi_awready = 1'b0;
    s_axi_wready  = 1'b0;
    s_axi_bvalid  = 1'b0;
    commit        = 1'b0;
    case (wstate_q)
      W_IDLE: begin
        s_axi_awready = 1'b1;
        s_axi_wready  = 1'b1;
        if (s_axi_awvalid && s_axi_wvalid) begin
          wstate_d = W_RESP;
          commit   = 1'b1;
        end else if (s_axi_awvalid) wstate_d = W_HAVE_AW;
        else if (s_axi_wvalid)      wstate_d = W_HAVE_W;
      end
      W_HAVE_AW: begin
        s_axi_wready = 1'b1;
        if (s_axi_wvalid) begin
          wstate_d = W_RESP;
          commit   = 1'b1;
        end
      end
      W_HAVE_W: begin
        s_axi_awready = 1'b1;
        if (s_axi_awvalid) begin
          wstate_d = W_RESP;
          commit   = 1'b1;
        end
      end
      default: begin
        s_axi_bvalid = 1'b1;
        if (s_axi_bready) wstate_d = W_IDLE;
      end
    endcase
  end

  always_comb begin
    rstate_d      = rstate_q;
    s_axi_arready = (rstate_q == R_IDLE);
    s_axi_rvalid  = (rstate_q == R_VALID);
    if (rstate_q == R_IDLE && s_axi_arvalid)      rstate_d = R_VALID;
    else if (rstate_q == R_VALID && s_axi_rready) rstate_d = R_IDLE;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wstate_q <= W_IDLE;
      rstate_q <= R_IDLE;
      awaddr_q <= '0;
      wdata_q  <= '0;
      wstrb_q  <= '0;
      rdata_q  <= '0;
      rresp_q  <= RESP_OKAY;
    end else begin
      wstate_q <= wstate_d;
      rstate_q <= rstate_d;
      if (s_axi_awvalid && s_axi_awready) awaddr_q <= s_axi_awaddr;
      if (s_axi_wvalid && s_axi_wready) begin
        wdata_q <= s_axi_wdata;
        wstrb_q <= s_axi_wstrb;
      end
      if (s_axi_arvalid && s_axi_arready) begin
        rdata_q <= rsel[31:0];
        rresp_q <= rsel[32] ? RESP_OKAY : RESP_SLVERR;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      bresp_q        <= RESP_OKAY;
      fp_leds_q      <= '0;
      dac_setpt_q    <= '0;
      dac_opmode_q   <= '0;
      ramp_len_q     <= '0;
      rampaddr_reg_q <= '0;
      ramp_addr_q    <= '0;
      ramp_wdata_q   <= '0;
      d0off_q        <= '0;
      d0gain_q       <= '0;
      d1off_q        <= '0;
      d1gain_q       <= '0;
      ramp_we_q      <= 1'b0;
      ramp_run_q     <= 1'b0;
    end else begin
      ramp_we_q  <= 1'b0;
      ramp_run_q <= 1'b0;
      if (commit) begin
        bresp_q <= wok ? RESP_OKAY : RESP_SLVERR;
        if (wok) begin
          case (wa)
            A_FP:       fp_leds_q      <= merged[7:0];
            A_SETPT:    dac_setpt_q    <= merged[19:0];
            A_OPMODE:   dac_opmode_q   <= merged[1:0];
            A_RAMPLEN:  ramp_len_q     <= merged[15:0];
            A_RAMPADDR: rampaddr_reg_q <= merged[15:0];
            A_D0OFF:    d0off_q        <= merged[15:0];
            A_D0GAIN:   d0gain_q       <= merged[15:0];
            A_D1OFF:    d1off_q        <= merged[15:0];
            A_D1GAIN:   d1gain_q       <= merged[15:0];
            A_RAMPDATA: if (ws[2:0] == 3'b111) begin
              ramp_we_q    <= 1'b1;
              ramp_addr_q  <= rampaddr_reg_q;
              ramp_wdata_q <= wd[19:0];
`ifdef PSC_RAMP_AUTOINC_EN
              rampaddr_reg_q <= rampaddr_reg_q + 16'd1;
`endif
            end
            A_RAMPRUN:  ramp_run_q <= ws[0] & wd[0];
            default: ;
          endcase
        end
      end
    end
  end

  assign s_axi_bresp  = bresp_q;
  assign s_axi_rdata  = rdata_q;
  assign s_axi_rresp  = rresp_q;
  assign fp_leds      = fp_leds_q;
  assign dac_setpt    = dac_setpt_q;
  assign dac_opmode   = dac_opmode_q;
  assign ramp_len     = ramp_len_q;
  assign ramp_we      = ramp_we_q;
  assign ramp_addr    = ramp_addr_q;
  assign ramp_wdata   = ramp_wdata_q;
  assign ramp_run     = ramp_run_q;
  assign dcct0_offset = d0off_q;
  assign dcct0_gain   = d0gain_q;
  assign dcct1_offset = d1off_q;
  assign dcct1_gain   = d1gain_q;
endmodule
